xnor_match_counter: RTL
=======================

// Module: xnor_match_counter
// PURPOSE
// - Downstream consumer of the XNOR equality primitive: compares two serial bit streams a/b
//   over a fixed frame of FRAME_LEN accepted bits.
// - Registers per-bit equality (y = a XNOR b) and counts matching bits.
// - Flags whole-frame equality and pulses done when the frame completes.
// - Sits after the bit-level comparator, feeding frame-level status logic.
// PARAMETERS
// - FRAME_LEN  8  number of accepted bits per frame; legal range >= 1
// - CNT_W      4  width of match_count and of the bit index; must satisfy 2**CNT_W > FRAME_LEN
// PORTS
// - clk          in   1      single clock; all state updates on posedge
// - rst_n        in   1      synchronous, active-low reset
// - start        in   1      request a new frame; sampled only in IDLE or DONE
// - bit_valid    in   1      a/b carry a bit this cycle; accepted only in RUN
// - a            in   1      stream A bit
// - b            in   1      stream B bit
// - busy         out  1      high while in RUN
// - y            out  1      registered a XNOR b of the last accepted bit
// - match_count  out  CNT_W  number of matching bits in the current or last frame
// - all_equal    out  1      1 when match_count == FRAME_LEN; valid with done, held after it
// - done         out  1      one-cycle pulse; frame complete
// BEHAVIOUR
// - Reset (rst_n==0 at posedge):
//   - state=IDLE; bit index=0.
//   - All outputs are 0: busy, y, match_count, all_equal, done.
//   - Reset mid-frame abandons the frame and drops any partial count.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE -> RUN when start==1. At the same edge, match_count=0, index=0 and all_equal=0.
//   - RUN: each cycle with bit_valid==1 accepts one bit.
//     - y <= ~(a^b).
//     - match_count += ~(a^b).
//     - index += 1.
//   - RUN: cycles with bit_valid==0 hold all state; y keeps its last value.
//   - RUN -> DONE on the edge that accepts bit index FRAME_LEN-1.
//     - Same edge: all_equal <= (final count == FRAME_LEN).
//   - DONE: lasts exactly one cycle with done=1.
//     - DONE -> IDLE if start==0.
//     - DONE -> RUN if start==1 (back-to-back frames; clears count/index as above).
// - Latency: y and match_count reflect an accepted bit 1 cycle after its edge.
//   done rises 1 cycle after the last bit is accepted. A frame with no idle cycles takes
//   FRAME_LEN+1 cycles from the start edge to the done cycle.
// - busy==1 exactly in RUN. done==1 exactly in DONE. done and busy are never high together.
// - Ignored events:
//   - start while in RUN is ignored.
//   - bit_valid in IDLE or DONE is ignored; y, count and index are unchanged.
// - Result hold: match_count/all_equal hold after DONE until the next accepted start.
// - Width rules: match_count never exceeds FRAME_LEN, so no wrap is possible under the
//   CNT_W rule. The index compare uses CNT_W-bit unsigned arithmetic.
// STRUCTURE
// - Shared package xnor_pkg: state typedef {IDLE, RUN, DONE} (2-bit encoding) and a
//   clog2-based helper constant for CNT_W.
// - One natural sub-module: xnorgate (1-bit a/b -> y), instantiated for the per-bit compare.
//   The FSM, counters and registers stay in this module.
// TESTING
// 1. Reset: hold rst_n=0 for 2 clocks with start=1, bit_valid=1.
//    -> busy=0, done=0, y=0, match_count=0, all_equal=0.
// 2. Equal frame: start, then 8 consecutive bits with a==b (pattern 1011_0010).
//    -> done pulses on cycle 9 after the start edge; match_count=8; all_equal=1;
//       y=1 on each bit.
// 3. Mixed frame: a=1010_1010, b=1111_0000, bit_valid gapped every other cycle.
//    -> match_count=4, all_equal=0; done comes 1 cycle after the 8th accepted bit;
//       busy holds through the gaps.
// 4. Back-to-back: start=1 held during DONE of an all-equal frame; next frame has a!=b on
//    all bits.
//    -> RUN re-entered with no IDLE cycle; second done shows match_count=0, all_equal=0.
// 5. Ignored inputs: start pulsed mid-RUN after 3 bits; bit_valid=1 while in IDLE.
//    -> frame count/index unaffected; the final match_count matches a reference model.
// 6. Reset mid-frame: rst_n=0 after 5 accepted bits, then a new full frame with a==b.
//    -> all outputs 0 after reset; the new frame reports match_count=8, all_equal=1.

Source files
------------

// File: rtl/xnor_match_counter_pkg.sv
// Shared types and constants for the XNOR frame match counter.
// Holds the 2-bit FSM state encoding and the default counter width.
package xnor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FRAME_LEN_DEF = 8;
  // Smallest width whose range covers 0..FRAME_LEN inclusive.
  localparam int CNT_W_DEF = $clog2(FRAME_LEN_DEF + 1);

endpackage

// File: rtl/xnor_match_counter_xnorgate.sv
// Single-bit equality primitive: y is high when a and b agree.
module xnorgate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_match_counter.sv
// Frame-level match counter: accepts FRAME_LEN serial a/b bits, counts equal
// bits, and pulses done with a whole-frame equality flag at frame end.
module xnor_match_counter
  import xnor_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             all_equal,
  output logic             done,
  output state_e           state_dbg
);

  // Handshake: a bit is consumed on any posedge where bit_valid==1 while busy==1;
  // there is no backpressure, and bit_valid outside RUN is dropped silently.

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             all_eq_q, all_eq_d;
  logic             bit_eq;
  logic [CNT_W-1:0] cnt_inc;

  xnorgate u_xnorgate (
    .a (a),
    .b (b),
    .y (bit_eq)
  );

  assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, bit_eq};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    all_eq_d = all_eq_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          idx_d    = '0;
          cnt_d    = '0;
          all_eq_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (bit_valid) begin
          y_d   = bit_eq;
          cnt_d = cnt_inc;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d  = ST_DONE;
            all_eq_d = (cnt_inc == FULL_CNT);
          end
        end
      end
      ST_DONE: begin
        // Holding start through DONE chains frames with no idle cycle.
        if (start) begin
          state_d  = ST_RUN;
          idx_d    = '0;
          cnt_d    = '0;
          all_eq_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      y_q      <= 1'b0;
      all_eq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      all_eq_q <= all_eq_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign y           = y_q;
  assign match_count = cnt_q;
  assign all_equal   = all_eq_q;
  assign state_dbg   = state_q;

endmodule
